// File: rtl/ltc2311_pkg.sv
// Shared register map, bit positions and FSM state types for the LTC2311 AXI4-Lite register block.
package ltc2311_pkg;

  // Word indices (byte offset = index * 4); only address bits [4:2] are decoded.
  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_DATA    = 3'd2;
  localparam logic [2:0] REG_POP_CNT = 3'd3;
  localparam logic [2:0] REG_ID      = 3'd4;

  localparam int STATUS_BUSY       = 0;
  localparam int STATUS_SLEEP      = 1;
  localparam int STATUS_CONTINUOUS = 2;
  localparam int STATUS_FULL       = 3;
  localparam int STATUS_EMPTY      = 4;

  localparam int CONTROL_READ       = 0;
  localparam int CONTROL_CONT_EN    = 1;
  localparam int CONTROL_CONT_DIS   = 2;
  localparam int CONTROL_SLEEP      = 3;
  localparam int CONTROL_WAKE       = 4;
  localparam int CONTROL_CLEAR_FIFO = 5;

  localparam logic [31:0] CONTROL_MASK = 32'h0000_003F;
  localparam logic [31:0] DATA_EMPTY   = 32'h8000_0000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

endpackage

// File: rtl/ltc2311_axil_regs.sv
// AXI4-Lite slave for the LTC2311 acquisition top: write pulses into control, status passthrough,
// pop-on-read sample FIFO access with a pop counter.
module ltc2311_axil_regs
  import ltc2311_pkg::*;
#(
  parameter int          ADDR_W      = 5,
  parameter logic [31:0] ID_VALUE    = 32'h2311_0001,
  parameter int          POP_HOLDOFF = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  input  logic [31:0]       status_reg_in,
  output logic [31:0]       control_reg_out,
  input  logic [31:0]       fifo_data_in,
  output logic              fifo_rd_en
);

  localparam int HW = $clog2(POP_HOLDOFF + 2);

  w_state_t      w_state, w_next;
  r_state_t      r_state, r_next;
  logic          up;
  logic          aw_held, w_held;
  logic [2:0]    aw_idx;
  logic [31:0]   w_data;
  logic          w_fire, wr_ctrl, wr_clr, wr_ok;
  logic          ar_fire, pop;
  logic [31:0]   rd_word;
  logic [1:0]    rd_resp;
  logic [HW-1:0] holdoff;
  logic [31:0]   pop_cnt;
  logic          unused;

  assign unused = ^{s_awaddr, s_araddr, fifo_data_in[31:16]};

  // ---------------- write channel ----------------
  // up keeps every ready low while in reset and for the first cycle after release.
  assign s_awready = up && (w_state == W_IDLE) && !aw_held;
  assign s_wready  = up && (w_state == W_IDLE) && !w_held;
  assign s_bvalid  = (w_state == W_RESP);

  assign w_fire  = (w_state == W_IDLE) && aw_held && w_held;
  assign wr_ok   = (aw_idx == REG_CONTROL) || (aw_idx == REG_POP_CNT);
  assign wr_ctrl = w_fire && (aw_idx == REG_CONTROL);
  assign wr_clr  = w_fire && (aw_idx == REG_POP_CNT);

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: if (aw_held && w_held) w_next = W_RESP;
      W_RESP: if (s_bready)          w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state         <= W_IDLE;
      up              <= 1'b0;
      aw_held         <= 1'b0;
      w_held          <= 1'b0;
      aw_idx          <= '0;
      w_data          <= '0;
      s_bresp         <= RESP_OKAY;
      control_reg_out <= '0;
    end else begin
      up              <= 1'b1;
      w_state         <= w_next;
      control_reg_out <= wr_ctrl ? (w_data & CONTROL_MASK) : '0;
      if (s_awvalid && s_awready) begin
        aw_held <= 1'b1;
        aw_idx  <= s_awaddr[4:2];
      end
      if (s_wvalid && s_wready) begin
        w_held <= 1'b1;
        w_data <= s_wdata;
      end
      if (w_fire) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        s_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // ---------------- read channel ----------------
  // Holdoff spans the registered-status lag so a stale empty bit can never trigger a second pop.
  assign s_arready = up && (r_state == R_IDLE) && (holdoff == '0);
  assign s_rvalid  = (r_state == R_DATA);
  assign ar_fire   = s_arvalid && s_arready;

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    pop     = 1'b0;
    unique case (s_araddr[4:2])
      REG_STATUS:  rd_word = status_reg_in;
      REG_CONTROL: rd_word = '0;
      REG_DATA: begin
        if (status_reg_in[STATUS_EMPTY]) begin
          rd_word = DATA_EMPTY;
        end else begin
          rd_word = {16'h0, fifo_data_in[15:0]};
          pop     = ar_fire;
        end
      end
      REG_POP_CNT: rd_word = pop_cnt;
      REG_ID:      rd_word = ID_VALUE;
      default:     rd_resp = RESP_SLVERR;
    endcase

    r_next = r_state;
    unique case (r_state)
      R_IDLE: if (ar_fire)  r_next = R_DATA;
      R_DATA: if (s_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= R_IDLE;
      s_rdata    <= '0;
      s_rresp    <= RESP_OKAY;
      fifo_rd_en <= 1'b0;
      holdoff    <= '0;
    end else begin
      r_state    <= r_next;
      fifo_rd_en <= pop;
      if (ar_fire) begin
        s_rdata <= rd_word;
        s_rresp <= rd_resp;
      end
      if (pop)                holdoff <= HW'(POP_HOLDOFF);
      else if (holdoff != '0) holdoff <= holdoff - HW'(1);
    end
  end

  // A clear landing on the same edge as a pop wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    pop_cnt <= '0;
    else if (wr_clr) pop_cnt <= '0;
    else if (pop)    pop_cnt <= pop_cnt + 32'd1;
  end

endmodule
